// File: rtl/grf_wb_queue_if.sv
// grf_wb_queue_if: producer handshake, register-file write port and pending-write lookup of the write-back queue
interface grf_wb_queue_if #(
  parameter int CW = 3
);
  logic          in_valid;
  logic          in_ready;
  logic [4:0]    in_a3;
  logic [31:0]   in_wd;
  logic [31:0]   in_pc;
  logic          drain_en;
  logic          grf_we;
  logic [4:0]    grf_a3;
  logic [31:0]   grf_wd;
  logic [31:0]   grf_pc;
  logic [CW-1:0] count;
  logic [4:0]    q_a1;
  logic [4:0]    q_a2;
  logic          q_hit1;
  logic          q_hit2;
  logic [31:0]   q_fwd1;
  logic [31:0]   q_fwd2;
  modport master (
    output in_valid, in_a3, in_wd, in_pc, drain_en, q_a1, q_a2,
    input  in_ready, grf_we, grf_a3, grf_wd, grf_pc, count, q_hit1, q_hit2, q_fwd1, q_fwd2
  );
  modport slave (
    input  in_valid, in_a3, in_wd, in_pc, drain_en, q_a1, q_a2,
    output in_ready, grf_we, grf_a3, grf_wd, grf_pc, count, q_hit1, q_hit2, q_fwd1, q_fwd2
  );
endinterface

// File: rtl/grf_wb_queue.sv
// grf_wb_queue: in-order write-back FIFO feeding the GRF write port, with two-port pending-write lookup
//   clk, reset : clock, synchronous active-high reset
//   bus        : producer valid/ready (in_*), drain_en, registered grf_* write port, count, lookup q_a*/q_hit*/q_fwd*
//   Define GRF_WB_TRACE_EN to print a trace line on every pop.
module grf_wb_queue #(
  parameter int DEPTH = 4,
  parameter int CW = 3
) (
  input logic clk,
  input logic reset,
  grf_wb_queue_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  logic [4:0]    a3_m [DEPTH];
  logic [31:0]   wd_m [DEPTH];
  logic [31:0]   pc_m [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] cnt;
  logic          we_r;
  logic [4:0]    a3_r;
  logic [31:0]   wd_r, pc_r;
  logic          push, pop, accept;
  assign bus.in_ready = cnt != CW'(DEPTH);
  assign accept = bus.in_valid && bus.in_ready;
  assign push = accept && bus.in_a3 != 5'd0;
  assign pop = bus.drain_en && cnt != '0;
  assign bus.count = cnt;
  assign bus.grf_we = we_r;
  assign bus.grf_a3 = a3_r;
  assign bus.grf_wd = wd_r;
  assign bus.grf_pc = pc_r;
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt <= '0;
      we_r <= 1'b0;
      a3_r <= '0;
      wd_r <= '0;
      pc_r <= '0;
    end else begin
      if (push) begin
        a3_m[wr_ptr] <= bus.in_a3;
        wd_m[wr_ptr] <= bus.in_wd;
        pc_m[wr_ptr] <= bus.in_pc;
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        a3_r <= a3_m[rd_ptr];
        wd_r <= wd_m[rd_ptr];
        pc_r <= pc_m[rd_ptr];
        rd_ptr <= rd_ptr + 1'b1;
`ifdef GRF_WB_TRACE_EN
        $display("@%h: $%d <= %h (wbq)", pc_m[rd_ptr], a3_m[rd_ptr], wd_m[rd_ptr]);
`endif
      end
      we_r <= pop;
      cnt <= cnt + CW'(push) - CW'(pop);
    end
  end
  // Scan from the grf stage through oldest-to-newest FIFO entries so the youngest match overwrites older ones.
  function automatic logic [32:0] find(input logic [4:0] a);
    logic [32:0] r;
    logic [AW-1:0] idx;
    r = (we_r && a3_r == a) ? {1'b1, wd_r} : 33'd0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = rd_ptr + AW'(k);
      if (CW'(k) < cnt && a3_m[idx] == a) r = {1'b1, wd_m[idx]};
    end
    return (a == 5'd0) ? 33'd0 : r;
  endfunction
  assign {bus.q_hit1, bus.q_fwd1} = find(bus.q_a1);
  assign {bus.q_hit2, bus.q_fwd2} = find(bus.q_a2);
endmodule

// File: tb/tb_grf_wb_queue.sv
// tb_grf_wb_queue: scoreboard bench for grf_wb_queue
module tb_grf_wb_queue;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int fails = 0;
  logic [68:0] sb[$];
  logic [68:0] e;
  grf_wb_queue_if #(.CW(3)) bus ();
  grf_wb_queue #(.DEPTH(4), .CW(3)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  // Every observed write must be the next expected one.
  always @(negedge clk) begin
    if (bus.grf_we) begin
      if (sb.size() == 0) chk("spurious_we", 64'd1, 64'd0);
      else begin
        e = sb.pop_front();
        chk("wb_a3", 64'(bus.grf_a3), 64'(e[68:64]));
        chk("wb_wd", 64'(bus.grf_wd), 64'(e[63:32]));
        chk("wb_pc", 64'(bus.grf_pc), 64'(e[31:0]));
      end
    end
  end
  task automatic push(input logic [4:0] a, input logic [31:0] d, input logic [31:0] p);
    bit ok;
    ok = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_a3 = a;
    bus.in_wd = d;
    bus.in_pc = p;
    for (int t = 0; t < 20 && !ok; t++) begin
      @(negedge clk);
      ok = bus.in_ready;
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    if (!ok) chk("push_timeout", 64'd0, 64'd1);
    else if (a != 5'd0) sb.push_back({a, d, p});
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  initial begin
    bus.in_valid = 1'b0;
    bus.in_a3 = '0;
    bus.in_wd = '0;
    bus.in_pc = '0;
    bus.drain_en = 1'b0;
    bus.q_a1 = '0;
    bus.q_a2 = '0;
    tick();
    tick();
    reset = 1'b0;
    @(negedge clk);
    chk("rst_count", 64'(bus.count), 64'd0);
    chk("rst_we", 64'(bus.grf_we), 64'd0);
    chk("rst_ready", 64'(bus.in_ready), 64'd1);
    chk("rst_a3", 64'(bus.grf_a3), 64'd0);
    chk("rst_wd", 64'(bus.grf_wd), 64'd0);
    chk("rst_pc", 64'(bus.grf_pc), 64'd0);
    tick();
    bus.drain_en = 1'b1;
    push(5'd5, 32'h12345678, 32'h3000);
    @(negedge clk);
    chk("single_cnt_inflight", 64'(bus.count), 64'd1);
    tick();
    @(negedge clk);
    chk("single_we", 64'(bus.grf_we), 64'd1);
    chk("single_cnt", 64'(bus.count), 64'd0);
    tick();
    @(negedge clk);
    chk("single_we_off", 64'(bus.grf_we), 64'd0);
    chk("single_cnt_end", 64'(bus.count), 64'd0);
    tick();
    bus.drain_en = 1'b0;
    for (int i = 1; i <= 4; i++) push(5'(i), 32'(i * 32'h11), 32'h4000 + 32'(4 * i));
    @(negedge clk);
    chk("fill_count", 64'(bus.count), 64'd4);
    chk("fill_ready", 64'(bus.in_ready), 64'd0);
    bus.in_valid = 1'b1;
    bus.in_a3 = 5'd9;
    bus.in_wd = 32'h99;
    tick();
    @(negedge clk);
    chk("full_refuse", 64'(bus.count), 64'd4);
    bus.in_valid = 1'b0;
    tick();
    bus.drain_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      @(negedge clk);
      chk("drain_we", 64'(bus.grf_we), 64'd1);
    end
    tick();
    @(negedge clk);
    chk("drain_done", 64'(bus.grf_we), 64'd0);
    bus.drain_en = 1'b0;
    tick();
    push(5'd10, 32'hA0, 32'h5000);
    push(5'd11, 32'hB0, 32'h5004);
    bus.drain_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      bus.in_valid = 1'b1;
      bus.in_a3 = 5'(12 + i);
      bus.in_wd = 32'hC00 + 32'(i);
      bus.in_pc = 32'h6000 + 32'(4 * i);
      @(negedge clk);
      chk("simul_count", 64'(bus.count), 64'd2);
      tick();
      sb.push_back({bus.in_a3, bus.in_wd, bus.in_pc});
    end
    bus.in_valid = 1'b0;
    repeat (4) tick();
    @(negedge clk);
    chk("simul_drained", 64'(bus.count), 64'd0);
    tick();
    push(5'd0, 32'hDEAD, 32'h7000);
    @(negedge clk);
    chk("zero_count", 64'(bus.count), 64'd0);
    tick();
    @(negedge clk);
    chk("zero_no_we", 64'(bus.grf_we), 64'd0);
    bus.drain_en = 1'b0;
    tick();
    push(5'd7, 32'hA, 32'h8000);
    push(5'd7, 32'hB, 32'h8004);
    bus.q_a1 = 5'd7;
    bus.q_a2 = 5'd0;
    @(negedge clk);
    chk("fwd_hit1", 64'(bus.q_hit1), 64'd1);
    chk("fwd_data1", 64'(bus.q_fwd1), 64'hB);
    chk("fwd_hit2_zero", 64'(bus.q_hit2), 64'd0);
    chk("fwd_data2_zero", 64'(bus.q_fwd2), 64'd0);
    tick();
    bus.drain_en = 1'b1;
    tick();
    @(negedge clk);
    chk("fwd_young_over_grf", 64'(bus.q_fwd1), 64'hB);
    bus.q_a2 = 5'd3;
    tick();
    @(negedge clk);
    chk("fwd_grf_hit", 64'(bus.q_hit1), 64'd1);
    chk("fwd_grf_data", 64'(bus.q_fwd1), 64'hB);
    chk("fwd_nomatch", 64'(bus.q_hit2), 64'd0);
    bus.drain_en = 1'b0;
    tick();
    @(negedge clk);
    chk("fwd_gone", 64'(bus.q_hit1), 64'd0);
    chk("fwd_gone_data", 64'(bus.q_fwd1), 64'd0);
    tick();
    for (int i = 0; i < 4; i++) push(5'(20 + i), 32'hE0 + 32'(i), 32'h9000 + 32'(4 * i));
    bus.drain_en = 1'b1;
    tick();
    bus.drain_en = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    chk("pre_rst_count", 64'(bus.count), 64'd3);
    chk("pre_rst_we", 64'(bus.grf_we), 64'd1);
    tick();
    reset = 1'b0;
    sb.delete();
    @(negedge clk);
    chk("mid_rst_count", 64'(bus.count), 64'd0);
    chk("mid_rst_we", 64'(bus.grf_we), 64'd0);
    chk("mid_rst_ready", 64'(bus.in_ready), 64'd1);
    bus.drain_en = 1'b1;
    repeat (6) tick();
    @(negedge clk);
    chk("end_sb_empty", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule

// File: doc/grf_wb_queue.md
Name: grf_wb_queue

Overview:
- In-order write-back buffer: the writer side of the general register file's single write port.
- Accepts register write requests (address, data, PC) from multi-cycle producers (MDU, late memory loads) through a valid/ready handshake.
- Buffers them in a small FIFO and issues at most one registered write per cycle on the register-file write port.
- Exposes a two-port pending-write lookup so the hazard unit can forward buffered values, or stall on them, before they reach the register file.

Parameters:
- DEPTH, 4: FIFO entries; power of two, at least 2.
- CW, 3: width of count; equals log2(DEPTH)+1.

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  producer presents a write request.
- in_ready  output  1  queue can accept; equals !full.
- in_a3  input  5  destination register.
- in_wd  input  32  write data.
- in_pc  input  32  PC of the producing instruction.
- drain_en  input  1  register-file write port is free this cycle.
- grf_we  output  1  write enable to the register file.
- grf_a3  output  5  write address to the register file.
- grf_wd  output  32  write data to the register file.
- grf_pc  output  32  PC to the register file, used for its trace.
- count  output  CW  number of valid FIFO entries; excludes the grf_* stage.
- q_a1, q_a2  input  5 each  lookup addresses.
- q_hit1, q_hit2  output  1 each  a pending write to that address exists.
- q_fwd1, q_fwd2  output  32 each  data of the youngest pending write to that address.

Behaviour:
- Push: occurs at the rising edge when in_valid && in_ready.
  - in_a3==0: request is handshaked but discarded; count unchanged.
- Pop: occurs at the rising edge when drain_en && count!=0.
  - Head entry is loaded into the grf_* registers and grf_we<=1.
  - Otherwise grf_we<=0. grf_a3, grf_wd and grf_pc hold their last values.
  - Latency: a request pushed at edge N into an empty queue, with drain_en held high, pops at edge N+1. grf_we is high during cycle N+1..N+2, and the register file commits at edge N+2.
- Simultaneous push and pop: both take effect; count unchanged.
- Full queue: in_ready=0 and pushes are refused. There is no same-cycle bypass even when a pop occurs.
- Empty queue: no pop; grf_we falls to 0 at the next edge.
- Order: strictly FIFO. Pointers wrap modulo DEPTH.
- Lookup, combinational:
  - Searches all valid FIFO entries plus the grf_* stage when grf_we=1.
  - Youngest match wins, with precedence newest FIFO entry > older FIFO entries > grf_* stage.
  - q_aX==0 or no match: q_hitX=0 and q_fwdX=0.
- Reset: count=0, pointers=0, grf_we=0, grf_a3=0, grf_wd=0, grf_pc=0.
  - Reset asserted mid-operation discards all queued and in-flight writes. No grf_we pulse is produced in the cycle after a reset edge.
  - Pushes and pops are ignored on reset edges.

Optional Feature:
- Macro GRF_WB_TRACE_EN.
- Defined: each pop executes $display("@%h: $%d <= %h (wbq)", head PC, head a3, head wd) at the pop edge.
- Not defined: no display statements are compiled; functional behaviour is identical.

Test Plan:
- Single write: after reset, push {a3=5, wd=0x12345678, pc=0x3000} with drain_en=1 -> next cycle grf_we=1, grf_a3=5, grf_wd=0x12345678, grf_pc=0x3000; the following cycle grf_we=0 and count=0.
- Fill and order: drain_en=0, push a3=1..4 with wd=0x11..0x44 -> count=4 and in_ready=0; a fifth push is refused. Raise drain_en -> grf_a3 sequence 1,2,3,4 on 4 consecutive cycles, then grf_we=0.
- Simultaneous push and pop at count=2 -> count stays 2. After 8 such cycles the pointers have wrapped, and the output order matches push order.
- Zero register: push a3=0 -> in_ready handshake completes, count stays 0, no grf_we pulse.
- Forwarding:
  - Queue holds a3=7/wd=0xA then a3=7/wd=0xB; q_a1=7 -> q_hit1=1, q_fwd1=0xB.
  - After both pop and grf_we deasserts -> q_hit1=0.
  - q_a2=0 -> q_hit2=0, q_fwd2=0.
- Reset mid-drain: count=3 with grf_we=1, assert reset one cycle -> count=0, grf_we=0, in_ready=1, and none of the queued writes appear afterwards.
